// File: rtl/instr_byte_loader_if.sv
// Byte-stream / instruction-memory bus of the boot loader.
// master: the loader itself. slave: the byte source and instruction memory side.
interface instr_byte_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic [7:0]        instr_i;
  logic              instr_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              load_done;
  logic              cpu_start;
  logic              ovf_err;

  modport master (
    input  instr_i, instr_valid, mem_ready,
    output mem_we, mem_addr, mem_wdata, load_done, cpu_start, ovf_err
  );

  modport slave (
    output instr_i, instr_valid, mem_ready,
    input  mem_we, mem_addr, mem_wdata, load_done, cpu_start, ovf_err
  );
endinterface

// File: rtl/instr_byte_loader.sv
// Instruction byte loader: packs a byte stream little-endian into 32-bit
// words, writes WORDS of them to instruction memory with a ready handshake,
// then flags completion and pulses cpu_start once to release the core.
module instr_byte_loader #(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  instr_byte_loader_if.master bus
);

  localparam logic [1:0] ST_LOAD  = 2'd0;  // assembling, no write pending
  localparam logic [1:0] ST_WRITE = 2'd1;  // write pending on the memory port
  localparam logic [1:0] ST_DONE  = 2'd2;  // all words written, CPU released

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  logic [1:0]        state;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_buf;    // first three bytes of the word in flight
  logic [ADDR_W-1:0] word_cnt;   // index of the next word to be written

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              load_done_q;
  logic              cpu_start_q;
  logic              ovf_err_q;

  logic              byte_take;
  logic              word_full;
  logic [31:0]       new_word;

  // Bytes are ignored once loading is finished.
  assign byte_take = bus.instr_valid && (state != ST_DONE);
  // The current byte is the fourth of its word.
  assign word_full = byte_take && (byte_cnt == 2'd3);
  assign new_word  = {bus.instr_i, asm_buf};

  // Byte counter and little-endian assembly of the first three bytes.
  always_ff @(posedge sys_clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // rather than in the sensitivity list.
    if (sys_reset) begin
      byte_cnt <= 2'd0;
      asm_buf  <= 24'd0;
    end else if (byte_take) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, so ordering inside the block does not matter.
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    asm_buf[7:0]   <= bus.instr_i;
        2'd1:    asm_buf[15:8]  <= bus.instr_i;
        2'd2:    asm_buf[23:16] <= bus.instr_i;
        default: ;  // fourth byte goes straight into new_word
      endcase
    end
  end

  // Load / write / done sequencing, memory port registers and status flags.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state       <= ST_LOAD;
      word_cnt    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      load_done_q <= 1'b0;
      cpu_start_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      cpu_start_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (word_full) begin
            mem_wdata_q <= new_word;
            mem_addr_q  <= word_cnt;
            mem_we_q    <= 1'b1;
            state       <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // mem_we is always high in this state, so ready alone completes it.
          if (bus.mem_ready) begin
            word_cnt <= word_cnt + ADDR_W'(1);
            if (word_cnt == LAST_WORD) begin
              mem_we_q    <= 1'b0;
              load_done_q <= 1'b1;
              cpu_start_q <= 1'b1;
              state       <= ST_DONE;
            end else if (word_full) begin
              // Hand the freshly completed word straight to the port.
              mem_wdata_q <= new_word;
              mem_addr_q  <= word_cnt + ADDR_W'(1);
            end else begin
              mem_we_q <= 1'b0;
              state    <= ST_LOAD;
            end
          end else if (word_full) begin
            // Port still busy: this word has nowhere to go and is dropped.
            ovf_err_q <= 1'b1;
          end
        end

        ST_DONE: ;  // only reset leaves DONE

        default: begin
          mem_we_q <= 1'b0;
          state    <= ST_LOAD;
        end
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.load_done = load_done_q;
  assign bus.cpu_start = cpu_start_q;
  assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_instr_byte_loader.sv
// Self-checking bench for instr_byte_loader: a vector table for the basic
// word assembly, hand sequences for stall/overflow/reset corners, and
// randomized streams checked against a queue-based reference model.
module tb_instr_byte_loader;

  localparam int WORDS  = 64;
  localparam int ADDR_W = 6;

  logic sys_clk = 1'b0;
  logic sys_reset;

  instr_byte_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_byte_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        r;
    logic        exp_we;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic r);
    bus.instr_valid = v;
    bus.instr_i     = b;
    bus.mem_ready   = r;
    tick();
  endtask

  // A byte is offered during reset to show it is not sampled.
  task automatic do_reset();
    sys_reset       = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_i     = 8'hEE;
    bus.mem_ready   = 1'b0;
    tick();
    sys_reset       = 1'b0;
    bus.instr_valid = 1'b0;
  endtask

  task automatic check_port(input string name, input logic exp_we,
                            input logic [5:0] exp_addr, input logic [31:0] exp_data);
    check({name, "_we"}, 32'(bus.mem_we), 32'(exp_we));
    if (exp_we) begin
      check({name, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
      check({name, "_data"}, bus.mem_wdata, exp_data);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_we"},    32'(bus.mem_we),    32'd0);
    check({name, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({name, "_data"},  bus.mem_wdata,      32'd0);
    check({name, "_done"},  32'(bus.load_done), 32'd0);
    check({name, "_start"}, 32'(bus.cpu_start), 32'd0);
    check({name, "_ovf"},   32'(bus.ovf_err),   32'd0);
  endtask

  // Randomized stream against a transaction-level model: bytes gather in a
  // queue, every fourth forms a word, a word is written only if the port is
  // free (or freed on that same edge), otherwise it is dropped and flagged.
  task automatic run_model(input int cycles, input int vpct, input int rpct,
                           output int dut_writes, output int starts, output int max_we_run);
    logic [7:0]  cur [$];
    int          m_written;
    bit          m_pend, m_done, m_ovf, m_start, completed, fire;
    logic [31:0] m_data, fresh;
    int          we_run;
    m_written = 0; m_pend = 0; m_done = 0; m_ovf = 0; m_start = 0;
    m_data = 0; fresh = 0; we_run = 0;
    dut_writes = 0; starts = 0; max_we_run = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      logic       v, r;
      logic [7:0] b;
      v = ($urandom_range(99) < vpct);
      r = ($urandom_range(99) < rpct);
      b = 8'($urandom);
      if (bus.mem_we && r) dut_writes++;
      m_start   = 0;
      completed = 0;
      if (!m_done) begin
        fire = m_pend && r;
        if (v) begin
          cur.push_back(b);
          if (cur.size() == 4) begin
            fresh = {cur[3], cur[2], cur[1], cur[0]};
            cur.delete();
            completed = 1;
          end
        end
        if (fire) begin
          m_written++;
          if (m_written == WORDS) begin
            m_done = 1; m_pend = 0; m_start = 1;
          end else if (completed) begin
            m_data = fresh;
          end else begin
            m_pend = 0;
          end
        end else if (completed) begin
          if (m_pend) m_ovf = 1;
          else begin
            m_pend = 1;
            m_data = fresh;
          end
        end
      end
      drive(v, b, r);
      check("rand_we", 32'(bus.mem_we), 32'(m_pend));
      if (m_pend) begin
        check("rand_addr", 32'(bus.mem_addr), 32'(m_written));
        check("rand_data", bus.mem_wdata, m_data);
      end
      check("rand_ovf",   32'(bus.ovf_err),   32'(m_ovf));
      check("rand_done",  32'(bus.load_done), 32'(m_done));
      check("rand_start", 32'(bus.cpu_start), 32'(m_start));
      if (bus.cpu_start) starts++;
      if (bus.mem_we) we_run++; else we_run = 0;
      if (we_run > max_we_run) max_we_run = we_run;
    end
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wr, st, run;

    // Word 00500513 back-to-back, then the same word with valid toggling.
    vecs[0]  = '{1'b1, 8'h13, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 8'h05, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 8'h50, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 8'h00, 1'b1, 1'b1, 6'd0, 32'h00500513, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 8'h13, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 8'h05, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 8'h50, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 8'hFF, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b1, 6'd1, 32'h00500513, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 32'h0,        1'b0};

    sys_reset       = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_i     = 8'h00;
    bus.mem_ready   = 1'b0;

    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].r);
      check_port($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data);
      check($sformatf("vec%0d_ovf", i), 32'(bus.ovf_err), 32'(vecs[i].exp_ovf));
    end

    // Word completes on the same edge the pending write completes.
    do_reset();
    drive(1, 8'h01, 0); drive(1, 8'h02, 0); drive(1, 8'h03, 0); drive(1, 8'h04, 0);
    check_port("same_w0", 1'b1, 6'd0, 32'h04030201);
    drive(1, 8'h05, 0); drive(1, 8'h06, 0); drive(1, 8'h07, 0);
    check_port("same_hold", 1'b1, 6'd0, 32'h04030201);
    drive(1, 8'h08, 1);
    check_port("same_w1", 1'b1, 6'd1, 32'h08070605);
    check("same_ovf", 32'(bus.ovf_err), 32'd0);
    drive(0, 8'h00, 1);
    check_port("same_end", 1'b0, 6'd0, 32'h0);

    // Six stalled cycles: word 1 completes while word 0 is pending.
    do_reset();
    drive(1, 8'hA0, 1); drive(1, 8'hA1, 1); drive(1, 8'hA2, 1); drive(1, 8'hA3, 1);
    check_port("stall_w0", 1'b1, 6'd0, 32'hA3A2A1A0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 8'(8'hB0 + i), 0);
      else       drive(0, 8'h00, 0);
      check_port($sformatf("stall%0d", i), 1'b1, 6'd0, 32'hA3A2A1A0);
      check($sformatf("stall%0d_ovf", i), 32'(bus.ovf_err), (i >= 3) ? 32'd1 : 32'd0);
    end
    drive(0, 8'h00, 1);
    check_port("stall_release", 1'b0, 6'd0, 32'h0);
    drive(1, 8'hC0, 1); drive(1, 8'hC1, 1); drive(1, 8'hC2, 1); drive(1, 8'hC3, 1);
    check_port("stall_w1", 1'b1, 6'd1, 32'hC3C2C1C0);
    check("stall_ovf_sticky", 32'(bus.ovf_err), 32'd1);
    check("stall_no_done", 32'(bus.load_done), 32'd0);

    // Reset mid-word (two bytes of word 3) and mid-write.
    do_reset();
    for (int i = 0; i < 12; i++) drive(1, 8'(i * 7 + 1), 1);
    check_port("rst_w2", 1'b1, 6'd2, {8'd78, 8'd71, 8'd64, 8'd57});
    drive(1, 8'h99, 1); drive(1, 8'h98, 1);
    do_reset();
    check_reset_state("rst_mid");
    drive(1, 8'h5A, 0); drive(1, 8'h6B, 0); drive(1, 8'h7C, 0); drive(1, 8'h8D, 0);
    check_port("rst_new", 1'b1, 6'd0, 32'h8D7C6B5A);
    do_reset();
    check("rst_write_we", 32'(bus.mem_we), 32'd0);
    drive(1, 8'h01, 0); drive(1, 8'h02, 0); drive(1, 8'h03, 0); drive(1, 8'h04, 0);
    check_port("rst_after_write", 1'b1, 6'd0, 32'h04030201);

    // Full back-to-back load with ready high, then bytes after done.
    run_model(300, 100, 100, wr, st, run);
    check("full_writes", 32'(wr), 32'd64);
    check("full_starts", 32'(st), 32'd1);
    check("full_we_run", 32'(run), 32'd1);
    check("full_ovf", 32'(bus.ovf_err), 32'd0);
    check("full_done", 32'(bus.load_done), 32'd1);

    // Random gaps and back-pressure.
    run_model(1500, 70, 50, wr, st, run);
    check("rand1_done", 32'(bus.load_done), 32'd1);
    check("rand1_starts", 32'(st), 32'd1);
    run_model(4000, 60, 15, wr, st, run);
    check("rand2_done", 32'(bus.load_done), 32'd1);
    check("rand2_writes", 32'(wr), 32'd64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_byte_loader.md
INSTR_BYTE_LOADER -- requirements
Module: instr_byte_loader

Interface
REQ-001 Parameter WORDS, default 64, is the number of 32-bit instruction words loaded before the CPU is released.
REQ-002 Parameter ADDR_W, default 6, is the word-address width; WORDS SHALL be at most 2**ADDR_W.
REQ-003 sys_clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 sys_reset  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 instr_i  input  8  is the instruction byte stream.
REQ-006 instr_valid  input  1  marks instr_i as carrying a byte this cycle.
REQ-007 mem_ready  input  1  means instruction memory accepts the presented write this cycle.
REQ-008 mem_we  output  1  is the instruction-memory write request.
REQ-009 mem_addr  output  ADDR_W  is the word address of the write.
REQ-010 mem_wdata  output  32  is the assembled instruction word.
REQ-011 load_done  output  1  means all WORDS words are written.
REQ-012 cpu_start  output  1  is a one-cycle pulse that releases the CPU core.
REQ-013 ovf_err  output  1  is a sticky flag meaning a completed word was dropped.

Function
REQ-014 The FSM SHALL have three states: LOAD (assembling, no write pending), WRITE (write pending) and DONE.
REQ-015 A byte SHALL be accepted at every rising edge where instr_valid=1 and state is LOAD or WRITE; gaps in instr_valid SHALL be allowed.
REQ-016 Assembly SHALL be little-endian: the first byte of a word goes to [7:0], the second to [15:8], the third to [23:16] and the fourth to [31:24].
REQ-017 A 2-bit byte counter SHALL wrap from 3 to 0 when a word completes.
REQ-018 When the 4th byte is accepted in LOAD at edge N, mem_wdata and mem_addr SHALL be registered and mem_we=1 from edge N, and the state SHALL become WRITE.
REQ-019 In WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable until an edge where mem_we=1 and mem_ready=1; that edge completes the write.
REQ-020 On write completion the word counter SHALL increment; mem_addr SHALL equal the word index, starting at 0.
REQ-021 On write completion of word WORDS-1 the state SHALL become DONE and mem_we SHALL be 0.
REQ-022 On any other write completion the state SHALL return to LOAD and mem_we SHALL be 0, unless REQ-023 applies.
REQ-023 If a word completes on the same edge that the pending write completes, the new word SHALL be presented immediately (mem_we stays 1, next address) and the state stays WRITE.
REQ-024 If a word completes in WRITE while the pending write does not complete, that word SHALL be discarded, ovf_err SHALL be set and the byte counter SHALL wrap to 0.
REQ-025 With mem_ready tied high and back-to-back bytes, mem_we SHALL be high for exactly one cycle per word, and no byte SHALL be lost.
REQ-026 On entry to DONE, load_done SHALL go to 1 and stay 1; cpu_start SHALL be 1 for exactly the first cycle in DONE.
REQ-027 In DONE, instr_valid and mem_ready SHALL be ignored and no further writes SHALL occur; only reset leaves DONE.
REQ-028 ovf_err SHALL remain set until reset.

Reset
REQ-029 While sys_reset=1 at an edge, the block SHALL go to LOAD with byte and word counters at 0, and instr_i SHALL not be sampled that cycle.
REQ-030 Reset values SHALL be: mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, cpu_start=0, ovf_err=0.
REQ-031 Reset asserted mid-word or mid-write SHALL abandon the partial word and the pending write; the next accepted byte after reset is byte 0 of word 0.

Verification
REQ-032 Bytes 13,05,50,00 (hex) on consecutive cycles with mem_ready=1 -> one mem_we cycle, mem_addr=0, mem_wdata=0x00500513.
REQ-033 256 back-to-back bytes with mem_ready=1 -> 64 single-cycle writes at mem_addr 0..63, load_done=1 after the 64th, one cpu_start pulse, ovf_err=0.
REQ-034 mem_ready held low for 6 cycles after word 0 completes while bytes keep streaming -> mem_we and data held stable, ovf_err=1 when word 1 completes, and word 1 is not written.
REQ-035 Reset after 2 bytes of word 3 followed by a fresh 4-byte stream -> write at mem_addr=0 with the new data.
REQ-036 Bytes sent after load_done=1 -> no mem_we, and cpu_start does not re-pulse.
REQ-037 instr_valid toggling 1,0,1,0 across a word -> the same assembled word as the back-to-back case.
